// File: rtl/beta_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : beta_pkg
//  Purpose  : Shared widths, shift-mode encodings and controller state type
//             for the iterative shifter sequencing controller.
//  Revision : 1.0  initial release
// ============================================================================
package beta_pkg;

   // Datapath width of the core
   localparam int XLEN        = 32;

   // Number of requesters competing for the shifter
   localparam int SHCTRL_NREQ = 2;

   // Field widths of a shift request
   localparam int SHAMT_W     = 5;
   localparam int MODE_W      = 2;

   // Shift-mode encodings; the fourth code point is reserved and illegal
   localparam logic [MODE_W-1:0] SHIFT_LEFT    = 2'b00;
   localparam logic [MODE_W-1:0] SHIFT_RIGHT   = 2'b01;
   localparam logic [MODE_W-1:0] SHIFT_ARIGHT  = 2'b10;
   localparam logic [MODE_W-1:0] SHIFT_ILLEGAL = 2'b11;

   // Controller sequencing states
   typedef enum logic [1:0] {
      SHCTRL_IDLE    = 2'd0,
      SHCTRL_SHIFT   = 2'd1,
      SHCTRL_CAPTURE = 2'd2,
      SHCTRL_RESP    = 2'd3
   } shctrl_state_t;

   // A request skips the shifter when there is nothing to shift or the
   // mode cannot be executed; the operand is returned unchanged.
   function automatic logic shctrl_is_bypass(input logic [SHAMT_W-1:0] shamt,
                                             input logic [MODE_W-1:0]  mode);
      return (shamt == '0) || (mode == SHIFT_ILLEGAL);
   endfunction

   // Requester id to one-hot channel vector
   function automatic logic [SHCTRL_NREQ-1:0] shctrl_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage : beta_pkg
`default_nettype wire

// File: rtl/beta_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : beta_rr_arb2
//  Purpose  : Two-way round-robin arbiter. A lone valid requester is granted
//             outright; on contention the priority pointer decides. The
//             pointer moves past the served requester on each advance strobe.
//  Revision : 1.0  initial release
// ============================================================================
module beta_rr_arb2
   import beta_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [SHCTRL_NREQ-1:0] valid_i,
   input  logic                   advance_i,
   output logic [SHCTRL_NREQ-1:0] grant_o
);

   // Priority pointer: id of the requester that wins a tie
   logic ptr_q;
   logic ptr_d;

   // One-hot grant from the valid vector and the tie-break pointer
   always_comb begin
      grant_o = '0;
      case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
         default: grant_o = '0;
      endcase
   end

   // After a served grant, priority passes to the requester not served
   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = ~grant_o[1];
      end
   end

   // Pointer register, requester 0 favoured out of reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule : beta_rr_arb2
`default_nettype wire

// File: rtl/beta_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : beta_shift_ctrl
//  Purpose  : Arbitrates two requesters onto the one-bit-per-cycle shifter,
//             runs it for exactly shamt enabled cycles, captures the result
//             and returns it on the owner's response channel. Zero-amount and
//             illegal-mode requests bypass the shifter.
//  Revision : 1.0  initial release
// ============================================================================
module beta_shift_ctrl
   import beta_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   // request channels
   input  logic [SHCTRL_NREQ-1:0] req_valid_i,
   output logic [SHCTRL_NREQ-1:0] req_ready_o,
   input  logic [XLEN-1:0]        req0_opa_i,
   input  logic [XLEN-1:0]        req1_opa_i,
   input  logic [SHAMT_W-1:0]     req0_shamt_i,
   input  logic [SHAMT_W-1:0]     req1_shamt_i,
   input  logic [MODE_W-1:0]      req0_mode_i,
   input  logic [MODE_W-1:0]      req1_mode_i,
   // response channels (result and err shared)
   output logic [SHCTRL_NREQ-1:0] resp_valid_o,
   input  logic [SHCTRL_NREQ-1:0] resp_ready_i,
   output logic [XLEN-1:0]        resp_result_o,
   output logic                   resp_err_o,
   // shifter control
   output logic                   shu_en_o,
   output logic [MODE_W-1:0]      shu_mode_o,
   output logic [XLEN-1:0]        shu_opa_o,
   output logic [SHAMT_W-1:0]     shu_shamt_o,
   input  logic [XLEN-1:0]        shu_result_i,
   // status
   output logic                   busy_o
);

   // ------------------------------------------------------------------
   // State and latched request
   // ------------------------------------------------------------------
   shctrl_state_t          state_q;
   logic [XLEN-1:0]        opa_q;
   logic [SHAMT_W-1:0]     shamt_q;
   logic [MODE_W-1:0]      mode_q;
   logic                   owner_q;
   logic                   bypass_q;
   logic [SHAMT_W-1:0]     cnt_q;
   logic [XLEN-1:0]        result_q;
   logic                   err_q;
   logic                   shu_en_q;
   logic [SHCTRL_NREQ-1:0] resp_valid_q;
   logic                   busy_q;

   // ------------------------------------------------------------------
   // Request selection
   // ------------------------------------------------------------------
   logic [SHCTRL_NREQ-1:0] arb_grant;
   logic [SHCTRL_NREQ-1:0] req_hs;
   logic                   accept;
   logic                   sel_id;
   logic [XLEN-1:0]        sel_opa;
   logic [SHAMT_W-1:0]     sel_shamt;
   logic [MODE_W-1:0]      sel_mode;
   logic                   sel_bypass;

   beta_rr_arb2 u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (req_valid_i),
      .advance_i (accept),
      .grant_o   (arb_grant)
   );

   // Ready is offered only to the granted requester, only while idle, and
   // never in a reset cycle so a request cannot slip in as state is cleared.
   assign req_ready_o = ((state_q == SHCTRL_IDLE) && !rst_i) ? arb_grant : '0;
   assign req_hs      = req_valid_i & req_ready_o;
   assign accept      = |req_hs;
   assign sel_id      = arb_grant[1];

   // Operand mux for the granted requester
   always_comb begin
      sel_opa   = req0_opa_i;
      sel_shamt = req0_shamt_i;
      sel_mode  = req0_mode_i;
      if (sel_id) begin
         sel_opa   = req1_opa_i;
         sel_shamt = req1_shamt_i;
         sel_mode  = req1_mode_i;
      end
   end

   assign sel_bypass = shctrl_is_bypass(sel_shamt, sel_mode);

   // ------------------------------------------------------------------
   // Sequencer: accept, shift for shamt cycles, capture, respond.
   // Bypassed requests still spend one cycle in CAPTURE (without sampling
   // the shifter) so the response appears one cycle after acceptance and
   // every request occupies the controller for at least two cycles.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= SHCTRL_IDLE;
         opa_q        <= '0;
         shamt_q      <= '0;
         mode_q       <= '0;
         owner_q      <= 1'b0;
         bypass_q     <= 1'b0;
         cnt_q        <= '0;
         result_q     <= '0;
         err_q        <= 1'b0;
         shu_en_q     <= 1'b0;
         resp_valid_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            SHCTRL_IDLE: begin
               if (accept) begin
                  opa_q    <= sel_opa;
                  shamt_q  <= sel_shamt;
                  mode_q   <= sel_mode;
                  owner_q  <= sel_id;
                  bypass_q <= sel_bypass;
                  busy_q   <= 1'b1;
                  if (sel_bypass) begin
                     result_q <= sel_opa;
                     err_q    <= (sel_mode == SHIFT_ILLEGAL);
                     cnt_q    <= '0;
                     state_q  <= SHCTRL_CAPTURE;
                  end else begin
                     err_q    <= 1'b0;
                     cnt_q    <= sel_shamt;
                     shu_en_q <= 1'b1;
                     state_q  <= SHCTRL_SHIFT;
                  end
               end
            end

            SHCTRL_SHIFT: begin
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  shu_en_q <= 1'b0;
                  state_q  <= SHCTRL_CAPTURE;
               end
            end

            SHCTRL_CAPTURE: begin
               if (!bypass_q) begin
                  result_q <= shu_result_i;
               end
               resp_valid_q <= shctrl_onehot(owner_q);
               state_q      <= SHCTRL_RESP;
            end

            SHCTRL_RESP: begin
               // only the owner's ready completes the response
               if (resp_ready_i[owner_q]) begin
                  resp_valid_q <= '0;
                  busy_q       <= 1'b0;
                  state_q      <= SHCTRL_IDLE;
               end
            end

            default: begin
               state_q <= SHCTRL_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs, all sourced from registers
   // ------------------------------------------------------------------
   assign shu_en_o      = shu_en_q;
   assign shu_opa_o     = opa_q;
   assign shu_shamt_o   = shamt_q;
   assign shu_mode_o    = mode_q;
   assign resp_valid_o  = resp_valid_q;
   assign resp_result_o = result_q;
   assign resp_err_o    = err_q;
   assign busy_o        = busy_q;

endmodule : beta_shift_ctrl
`default_nettype wire

// File: tb/tb_beta_shift_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_beta_shift_ctrl
//  Purpose  : Scoreboard bench for beta_shift_ctrl with an iterative shifter
//             model and a direct-arithmetic reference for expected results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_beta_shift_ctrl;
   import beta_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [1:0]  req_valid_i = '0;
   logic [1:0]  req_ready_o;
   logic [31:0] req0_opa_i = '0, req1_opa_i = '0;
   logic [4:0]  req0_shamt_i = '0, req1_shamt_i = '0;
   logic [1:0]  req0_mode_i = '0, req1_mode_i = '0;
   logic [1:0]  resp_valid_o;
   logic [1:0]  resp_ready_i = '0;
   logic [31:0] resp_result_o;
   logic        resp_err_o;
   logic        shu_en_o;
   logic [1:0]  shu_mode_o;
   logic [31:0] shu_opa_o;
   logic [4:0]  shu_shamt_o;
   logic [31:0] shu_result_i;
   logic        busy_o;

   always #5 clk_i = ~clk_i;

   beta_shift_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req0_opa_i(req0_opa_i), .req1_opa_i(req1_opa_i),
      .req0_shamt_i(req0_shamt_i), .req1_shamt_i(req1_shamt_i),
      .req0_mode_i(req0_mode_i), .req1_mode_i(req1_mode_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_result_o(resp_result_o), .resp_err_o(resp_err_o),
      .shu_en_o(shu_en_o), .shu_mode_o(shu_mode_o), .shu_opa_o(shu_opa_o),
      .shu_shamt_o(shu_shamt_o), .shu_result_i(shu_result_i),
      .busy_o(busy_o)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Iterative shifter: one bit per enabled cycle, first bit from shu_opa_o
   logic [31:0] shu_q;
   logic        shu_prev_en;

   function automatic logic [31:0] step1(input logic [31:0] x, input logic [1:0] m);
      case (m)
         SHIFT_LEFT:  return x << 1;
         SHIFT_RIGHT: return x >> 1;
         default:     return {x[31], x[31:1]};
      endcase
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) begin
         shu_q       <= '0;
         shu_prev_en <= 1'b0;
      end else begin
         if (shu_en_o) shu_q <= step1(shu_prev_en ? shu_q : shu_opa_o, shu_mode_o);
         shu_prev_en <= shu_en_o;
      end
   end
   assign shu_result_i = shu_q;

   // Reference: whole-word shift by the requested amount
   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] n,
                                             input logic [1:0] m);
      logic signed [31:0] s;
      s = a;
      if (n == 5'd0 || m == 2'b11) return a;
      case (m)
         SHIFT_LEFT:  return a << n;
         SHIFT_RIGHT: return a >> n;
         default:     return 32'(s >>> n);
      endcase
   endfunction

   typedef struct {
      logic        owner;
      logic [31:0] result;
      logic        err;
      int          first_cyc;
      int          en_cycles;
   } exp_t;

   exp_t sb_q[$];

   // ------------------------------------------------------------------
   // Monitor: per-cycle response checks and handshake pop
   // ------------------------------------------------------------------
   int en_count   = 0;
   bit in_resp    = 1'b0;
   int first_seen = 0;

   always @(negedge clk_i) begin
      if (rst_i) begin
         sb_q.delete();
         en_count = 0;
         in_resp  = 1'b0;
      end else begin
         if (shu_en_o) en_count++;
         if (!in_resp && resp_valid_o != 2'b00) begin
            if (sb_q.size() == 0) check("resp_unexpected", resp_valid_o, 2'b00);
            else begin
               in_resp    = 1'b1;
               first_seen = cyc;
            end
         end
         if (in_resp) begin
            if (resp_valid_o == 2'b00) begin
               check("resp_valid_dropped", resp_valid_o, sb_q[0].owner ? 2'b10 : 2'b01);
               void'(sb_q.pop_front());
               in_resp  = 1'b0;
               en_count = 0;
            end else begin
               check("resp_valid", resp_valid_o, sb_q[0].owner ? 2'b10 : 2'b01);
               check("resp_result", resp_result_o, sb_q[0].result);
               check("resp_err", resp_err_o, sb_q[0].err);
               if (resp_ready_i[sb_q[0].owner]) begin
                  check("resp_latency_cycle", first_seen, sb_q[0].first_cyc);
                  check("shu_en_cycles", en_count, sb_q[0].en_cycles);
                  void'(sb_q.pop_front());
                  in_resp  = 1'b0;
                  en_count = 0;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Response-ready driver
   // ------------------------------------------------------------------
   int         rdy_mode  = 0;
   logic [1:0] rdy_force = 2'b00;

   always @(posedge clk_i) begin
      #1;
      case (rdy_mode)
         0:       resp_ready_i = 2'b11;
         1:       resp_ready_i = 2'($urandom_range(0, 3));
         default: resp_ready_i = rdy_force;
      endcase
   end

   // ------------------------------------------------------------------
   // Request driver and arbitration model
   // ------------------------------------------------------------------
   logic [1:0]  pend = 2'b00;
   logic [31:0] p_opa[2];
   logic [4:0]  p_shamt[2];
   logic [1:0]  p_mode[2];
   bit          tb_ptr    = 1'b0;
   bit          rand_on   = 1'b0;
   int          rand_pct  = 0;
   int          fix_shamt = -1;

   task automatic drive();
      req_valid_i  = pend;
      req0_opa_i   = p_opa[0];   req1_opa_i   = p_opa[1];
      req0_shamt_i = p_shamt[0]; req1_shamt_i = p_shamt[1];
      req0_mode_i  = p_mode[0];  req1_mode_i  = p_mode[1];
   endtask

   task automatic new_payload(input int r);
      p_opa[r] = $urandom;
      if (fix_shamt >= 0) p_shamt[r] = 5'(fix_shamt);
      else p_shamt[r] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      p_mode[r] = 2'($urandom_range(0, (fix_shamt >= 0) ? 2 : 3));
      pend[r]   = 1'b1;
   endtask

   task automatic issue(input int r, input logic [31:0] opa, input logic [4:0] sh,
                        input logic [1:0] m);
      p_opa[r] = opa; p_shamt[r] = sh; p_mode[r] = m; pend[r] = 1'b1;
      drive();
   endtask

   task automatic accept_model(input int w);
      exp_t e;
      bit   byp;
      byp         = (p_shamt[w] == 5'd0) || (p_mode[w] == 2'b11);
      e.owner     = (w == 1);
      e.result    = ref_shift(p_opa[w], p_shamt[w], p_mode[w]);
      e.err       = (p_mode[w] == 2'b11);
      e.first_cyc = cyc + 2 + (byp ? 0 : int'(p_shamt[w]));
      e.en_cycles = byp ? 0 : int'(p_shamt[w]);
      sb_q.push_back(e);
      pend[w] = 1'b0;
      tb_ptr  = (w == 0);
   endtask

   // One cycle: observe the request handshake at negedge, drive after posedge
   task automatic tick();
      @(negedge clk_i);
      if (!rst_i && req_ready_o != 2'b00) begin
         logic [1:0] eg;
         eg = (pend == 2'b11) ? (tb_ptr ? 2'b10 : 2'b01) : pend;
         check("grant", req_ready_o, eg);
         if (eg != 2'b00) accept_model(eg[1] ? 1 : 0);
      end
      @(posedge clk_i);
      #1;
      if (rand_on)
         for (int r = 0; r < 2; r++)
            if (!pend[r] && $urandom_range(0, 99) < rand_pct) new_payload(r);
      drive();
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((pend != 2'b00 || sb_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain_outstanding", {pend, 30'(sb_q.size())}, 0);
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      for (int r = 0; r < 2; r++) begin
         p_opa[r] = '0; p_shamt[r] = '0; p_mode[r] = '0;
      end
      rst_i = 1'b1;
      drive();
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;

      @(negedge clk_i);
      check("reset_busy", busy_o, 0);
      check("reset_shu_en", shu_en_o, 0);
      check("reset_resp_valid", resp_valid_o, 0);
      check("reset_result", resp_result_o, 0);
      check("reset_err", resp_err_o, 0);
      check("reset_req_ready", req_ready_o, 0);
      @(posedge clk_i);
      #1;

      // arithmetic right shift, then a zero-amount bypass
      issue(0, 32'h8000_0001, 5'd4, SHIFT_ARIGHT);
      wait_drain(30);
      issue(1, 32'h0000_00FF, 5'd0, SHIFT_LEFT);
      wait_drain(30);

      // both requesters continuously valid with single-bit shifts
      fix_shamt = 1;
      new_payload(0);
      new_payload(1);
      drive();
      rand_on = 1'b1; rand_pct = 100;
      repeat (16) tick();
      rand_on = 1'b0;
      fix_shamt = -1;
      wait_drain(40);

      // illegal mode returns the operand with err set
      issue(0, 32'h1234_5678, 5'd7, 2'b11);
      wait_drain(30);

      // response held back; non-owner ready must not complete it
      rdy_mode = 2; rdy_force = 2'b10;
      issue(0, 32'hFFFF_FFFF, 5'd31, SHIFT_RIGHT);
      for (int n = 0; n < 60 && !in_resp; n++) tick();
      repeat (5) tick();
      rdy_force = 2'b01;
      wait_drain(20);
      rdy_mode = 0;

      // randomized traffic with random response back-pressure
      rdy_mode = 1; rand_on = 1'b1; rand_pct = 30;
      repeat (2500) tick();
      rand_on = 1'b0;
      rdy_mode = 0;
      wait_drain(400);

      // reset in the middle of a shift drops the request
      issue(0, 32'hA5A5_0F0F, 5'd20, SHIFT_ARIGHT);
      repeat (4) tick();
      rst_i = 1'b1;
      @(negedge clk_i);
      check("pre_reset_shu_en", shu_en_o, 1);
      check("reset_cycle_req_ready", req_ready_o, 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      pend = 2'b00; tb_ptr = 1'b0;
      drive();
      @(negedge clk_i);
      check("post_reset_shu_en", shu_en_o, 0);
      check("post_reset_busy", busy_o, 0);
      check("post_reset_resp_valid", resp_valid_o, 0);
      @(posedge clk_i);
      #1;
      // fresh contention after reset must favour requester 0
      issue(0, 32'h0F00_00F0, 5'd3, SHIFT_LEFT);
      issue(1, 32'h8000_0000, 5'd2, SHIFT_ARIGHT);
      wait_drain(60);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_beta_shift_ctrl
`default_nettype wire
